text_term_ctrl: RTL and testbench

Terminal-style owner of the single-port character memory that feeds the VGA text pipeline. Accepts an ASCII byte stream over a valid/ready handshake, maintains cursor and hardware scroll offset, writes characters into the buffer, and arbitrates the one memory port between display reads (absolute priority) and terminal writes. The display side supplies a logical (row, col) and receives the character from the scrolled physical location one cycle later.

---
 rtl/text_term_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_text_term_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_term_ctrl.sv
// text_term_ctrl
// Terminal-style owner of the single-port character memory behind the VGA
// text pipeline. Takes an ASCII byte stream, tracks the cursor and the
// hardware scroll offset, writes characters into the buffer, and shares the
// one memory port between display reads (always win) and terminal writes.
//
// Optional feature: define TERM_CLEAR_ON_RESET_EN to blank the whole buffer
// with spaces after every reset before the first byte is accepted.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_char/in_ready   byte stream handshake
//   disp_req/disp_row/disp_col  display read request (logical row, column)
//   disp_char               character for the request of the previous cycle
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port memory, 1-cycle read
//   cur_row/cur_col         cursor position (logical row)
//   top_row                 physical row shown as logical row 0
module text_term_ctrl #(
  parameter int h_disp = 1280,
  parameter int v_disp = 1024,
  localparam int COLS   = h_disp / 8,
  localparam int ROWS   = v_disp / 8,
  localparam int col_w  = $clog2(COLS),
  localparam int row_w  = $clog2(ROWS),
  localparam int addr_w = $clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_char,
  output logic              in_ready,
  input  logic              disp_req,
  input  logic [row_w-1:0]  disp_row,
  input  logic [col_w-1:0]  disp_col,
  output logic [7:0]        disp_char,
  output logic [addr_w-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [row_w-1:0]  cur_row,
  output logic [col_w-1:0]  cur_col,
  output logic [row_w-1:0]  top_row
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUT   = 2'd1,
    CLEAR = 2'd2
`ifdef TERM_CLEAR_ON_RESET_EN
    , CLR_ALL = 2'd3
`endif
  } state_t;

`ifdef TERM_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLR_ALL;
  localparam logic [addr_w-1:0] CELL_LAST = addr_w'(COLS * ROWS - 1);
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  localparam logic [col_w-1:0] COL_LAST = col_w'(COLS - 1);
  localparam logic [row_w-1:0] ROW_LAST = row_w'(ROWS - 1);

  state_t             state_reg;
  logic [7:0]         char_reg;
  logic [row_w-1:0]   cur_row_reg;
  logic [col_w-1:0]   cur_col_reg;
  logic [row_w-1:0]   top_row_reg;
  logic [col_w-1:0]   clr_col_reg;
`ifdef TERM_CLEAR_ON_RESET_EN
  logic [addr_w-1:0]  clr_addr_reg;
`endif

  // Logical (row, col) -> physical address through the scroll offset.
  function automatic logic [addr_w-1:0] xlate(
    input logic [row_w-1:0] top,
    input logic [row_w-1:0] row,
    input logic [col_w-1:0] col
  );
    logic [row_w:0]   sum;
    logic [row_w-1:0] prow;
    sum = {1'b0, top} + {1'b0, row};
    if (sum >= (row_w+1)'(ROWS))
      sum = sum - (row_w+1)'(ROWS);
    prow = sum[row_w-1:0];
    return addr_w'(prow) * addr_w'(COLS) + addr_w'(col);
  endfunction

  // Byte classification of the latched character
  logic is_print, is_lf, is_cr, is_bs, col_nonzero;
  assign is_print    = (char_reg >= 8'h20) && (char_reg <= 8'h7E);
  assign is_lf       = (char_reg == 8'h0A);
  assign is_cr       = (char_reg == 8'h0D);
  assign is_bs       = (char_reg == 8'h08);
  assign col_nonzero = (cur_col_reg != '0);

  logic [col_w-1:0] bs_col;
  assign bs_col = cur_col_reg - col_w'(1);

  // PUT only has to wait for the port when it actually writes something
  logic put_write;
  assign put_write = (state_reg == PUT) && (is_print || (is_bs && col_nonzero));

  // Row advance: line feed, or a printable landing in the last column
  logic newline;
  assign newline = is_lf || (is_print && (cur_col_reg == COL_LAST));

  logic [col_w-1:0] col_next;
  always_comb begin
    col_next = cur_col_reg;
    if (is_print)
      col_next = (cur_col_reg == COL_LAST) ? '0 : cur_col_reg + col_w'(1);
    else if (is_lf || is_cr)
      col_next = '0;
    else if (is_bs && col_nonzero)
      col_next = bs_col;
  end

  logic [row_w-1:0] top_next;
  assign top_next = (top_row_reg == ROW_LAST) ? '0 : top_row_reg + row_w'(1);

  // Writer-side request
  logic              wr_req;
  logic [addr_w-1:0] wr_addr;
  logic [7:0]        wr_data;
  always_comb begin
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = 8'h20;
    case (state_reg)
      PUT: begin
        if (is_print) begin
          wr_req  = 1'b1;
          wr_addr = xlate(top_row_reg, cur_row_reg, cur_col_reg);
          wr_data = char_reg;
        end else if (is_bs && col_nonzero) begin
          wr_req  = 1'b1;
          wr_addr = xlate(top_row_reg, cur_row_reg, bs_col);
        end
      end
      CLEAR: begin
        // top_row already advanced, so logical ROW_LAST is the recycled row
        wr_req  = 1'b1;
        wr_addr = xlate(top_row_reg, ROW_LAST, clr_col_reg);
      end
`ifdef TERM_CLEAR_ON_RESET_EN
      CLR_ALL: begin
        wr_req  = 1'b1;
        wr_addr = clr_addr_reg;
      end
`endif
      default: begin
        wr_req = 1'b0;
      end
    endcase
  end

  // Port arbitration: display reads always win; reset blocks writes outright
  logic [addr_w-1:0] disp_addr;
  assign disp_addr = xlate(top_row_reg, disp_row, disp_col);

  assign mem_we    = wr_req && !disp_req && !reset;
  assign mem_addr  = disp_req ? disp_addr : wr_addr;
  assign mem_wdata = wr_data;
  assign disp_char = mem_rdata;

  assign in_ready = (state_reg == IDLE);
  assign cur_row  = cur_row_reg;
  assign cur_col  = cur_col_reg;
  assign top_row  = top_row_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RESET_STATE;
      char_reg    <= '0;
      cur_row_reg <= '0;
      cur_col_reg <= '0;
      top_row_reg <= '0;
      clr_col_reg <= '0;
`ifdef TERM_CLEAR_ON_RESET_EN
      clr_addr_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            char_reg  <= in_char;
            state_reg <= PUT;
          end
        end
        PUT: begin
          // Hold the byte while a display read owns the port
          if (!(put_write && disp_req)) begin
            cur_col_reg <= col_next;
            state_reg   <= IDLE;
            if (newline) begin
              if (cur_row_reg == ROW_LAST) begin
                top_row_reg <= top_next;
                clr_col_reg <= '0;
                state_reg   <= CLEAR;
              end else begin
                cur_row_reg <= cur_row_reg + row_w'(1);
              end
            end
          end
        end
        CLEAR: begin
          if (!disp_req) begin
            if (clr_col_reg == COL_LAST)
              state_reg <= IDLE;
            else
              clr_col_reg <= clr_col_reg + col_w'(1);
          end
        end
`ifdef TERM_CLEAR_ON_RESET_EN
        CLR_ALL: begin
          if (!disp_req) begin
            if (clr_addr_reg == CELL_LAST)
              state_reg <= IDLE;
            else
              clr_addr_reg <= clr_addr_reg + addr_w'(1);
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Testbench for text_term_ctrl (default build). A behavioural terminal model
// (cursor, scroll offset, screen contents) predicts every memory write and
// cursor state; a simple synchronous RAM answers the DUT's reads.
module tb_text_term_ctrl;

  localparam int COLS  = 160;
  localparam int ROWS  = 128;
  localparam int NCELL = COLS * ROWS;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        disp_req;
  logic [6:0]  disp_row;
  logic [7:0]  disp_col;
  logic [7:0]  disp_char;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [6:0]  cur_row;
  logic [7:0]  cur_col;
  logic [6:0]  top_row;

  text_term_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .disp_req  (disp_req),
    .disp_row  (disp_row),
    .disp_col  (disp_col),
    .disp_char (disp_char),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .top_row   (top_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-first
  logic [7:0] ram [0:NCELL-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Write monitor, sampled mid-cycle when inputs are stable
  int obs_a[$];
  int obs_d[$];
  int viol;
  initial viol = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_a.push_back(int'(mem_addr));
      obs_d.push_back(int'(mem_wdata));
      if (disp_req !== 1'b0 || reset !== 1'b0) viol++;
    end
  end

  // Reference model
  int m_row, m_col, m_top;
  int scr [NCELL];        // expected physical contents, -1 = unknown
  int exp_a[$];
  int exp_d[$];
  int n_tests, n_fail;
  int last_cyc;

  function automatic int m_addr(input int r, input int c);
    return ((m_top + r) % ROWS) * COLS + c;
  endfunction

  task automatic m_newline();
    if (m_row < ROWS - 1) m_row++;
    else begin
      m_top = (m_top + 1) % ROWS;
      for (int c = 0; c < COLS; c++) begin
        exp_a.push_back(m_addr(ROWS - 1, c));
        exp_d.push_back(32);
      end
    end
  endtask

  task automatic model_byte(input int b);
    exp_a.delete();
    exp_d.delete();
    if (b >= 32 && b <= 126) begin
      exp_a.push_back(m_addr(m_row, m_col));
      exp_d.push_back(b);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_newline();
      end
    end else if (b == 10) begin
      m_col = 0;
      m_newline();
    end else if (b == 13) begin
      m_col = 0;
    end else if (b == 8) begin
      if (m_col > 0) begin
        m_col--;
        exp_a.push_back(m_addr(m_row, m_col));
        exp_d.push_back(32);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one byte; display requests forced for 'hold' cycles, then random at pct%
  task automatic send_byte(input int b, input int hold, input int pct);
    int cyc;
    int n;
    model_byte(b);
    obs_a.delete();
    obs_d.delete();
    check("in_ready_before", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_char  = 8'(b);
    disp_req = 1'b0;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 2000) begin
      disp_req = (cyc < hold) || ($urandom_range(99) < pct);
      disp_row = 7'($urandom);
      disp_col = 8'($urandom_range(COLS - 1));
      tick();
      cyc++;
    end
    disp_req = 1'b0;
    last_cyc = cyc;
    check("done_in_time", 32'(cyc < 2000), 1);
    check("write_count", obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check("wr_addr", obs_a[i], exp_a[i]);
      check("wr_data", obs_d[i], exp_d[i]);
    end
    check("cur_row", 32'(cur_row), m_row);
    check("cur_col", 32'(cur_col), m_col);
    check("top_row", 32'(top_row), m_top);
    for (int i = 0; i < exp_a.size(); i++) scr[exp_a[i]] = exp_d[i];
    $display("[TB] byte %02h -> row %0d col %0d top %0d writes %0d busy %0d",
             b, m_row, m_col, m_top, obs_a.size(), cyc);
  endtask

  task automatic disp_one(input int r, input int c);
    int a;
    a = m_addr(r, c);
    disp_req = 1'b1;
    disp_row = 7'(r);
    disp_col = 8'(c);
    #1;
    check("disp_addr", 32'(mem_addr), a);
    check("disp_no_we", 32'(mem_we), 0);
    tick();
    disp_req = 1'b0;
    if (scr[a] >= 0) check("disp_char", 32'(disp_char), scr[a]);
  endtask

  task automatic disp_random(input int n);
    int r, c;
    for (int i = 0; i < n; i++) begin
      r = -1;
      c = 0;
      for (int t = 0; t < 300 && r < 0; t++) begin
        r = $urandom_range(ROWS - 1);
        c = $urandom_range(COLS - 1);
        if (scr[m_addr(r, c)] < 0) r = -1;
      end
      if (r >= 0) disp_one(r, c);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n;
    int other [5];
    other[0] = 8'h00; other[1] = 8'h1B; other[2] = 8'h7F; other[3] = 8'hFF; other[4] = 8'h09;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < NCELL; i++) scr[i] = -1;
    m_row = 0; m_col = 0; m_top = 0;
    reset = 1'b1; in_valid = 1'b0; in_char = 8'h00;
    disp_req = 1'b0; disp_row = '0; disp_col = '0;

    // Reset state
    repeat (3) begin
      tick();
      check("we_in_reset", 32'(mem_we), 0);
    end
    reset = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_cur_row", 32'(cur_row), 0);
    check("rst_cur_col", 32'(cur_col), 0);
    check("rst_top_row", 32'(top_row), 0);
    check("rst_mem_we", 32'(mem_we), 0);

    // First character, no contention
    send_byte(8'h41, 0, 0);
    check("A_addr", (obs_a.size() > 0) ? obs_a[0] : -1, 0);
    check("A_busy", last_cyc, 1);
    check("A_col", 32'(cur_col), 1);

    // Character held off by 5 display cycles
    send_byte(8'h42, 5, 0);
    check("B_addr", (obs_a.size() > 0) ? obs_a[0] : -1, 1);
    check("B_busy", last_cyc, 6);

    // Move to column 7 then carriage return
    for (int i = 0; i < 5; i++) send_byte(8'h43 + i, 0, 30);
    check("col7", 32'(cur_col), 7);
    send_byte(8'h0D, 0, 0);
    check("cr_nowrite", obs_a.size(), 0);

    // Fill a whole row
    for (int i = 0; i < COLS; i++) send_byte(8'h30, 0, 25);
    check("wrap_row", 32'(cur_row), 1);
    check("wrap_col", 32'(cur_col), 0);
    send_byte(8'h31, 0, 0);
    check("wrap_addr", (obs_a.size() > 0) ? obs_a[0] : -1, 160);
    disp_random(20);

    // Backspace behaviour
    for (int i = 0; i < 4; i++) send_byte(8'h61 + i, 0, 20);
    send_byte(8'h08, 2, 20);
    check("bs_addr", (obs_a.size() > 0) ? obs_a[0] : -1, 164);
    check("bs_col", 32'(cur_col), 4);
    for (int i = 0; i < 4; i++) send_byte(8'h08, 0, 20);
    send_byte(8'h08, 0, 0);
    check("bs0_nowrite", obs_a.size(), 0);
    check("bs0_col", 32'(cur_col), 0);

    // Random byte mix
    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(9);
      if (n <= 5) b = $urandom_range(32, 126);
      else if (n == 6) b = 10;
      else if (n == 7) b = 13;
      else if (n == 8) b = 8;
      else b = other[$urandom_range(4)];
      send_byte(b, 0, 30);
    end
    disp_random(20);

    // Walk down to the bottom row, then scroll with a line feed
    while (m_row < ROWS - 1) send_byte(8'h0A, 0, 20);
    send_byte(8'h0A, 0, 0);
    check("scroll_busy", last_cyc, 161);
    check("scroll_top", 32'(top_row), 1);
    check("scroll_first", (obs_a.size() > 0) ? obs_a[0] : -1, 0);
    check("scroll_last", (obs_a.size() > 0) ? obs_a[obs_a.size() - 1] : -1, 159);
    disp_one(ROWS - 1, 0);
    check("bottom_reads_addr0_char", 32'(disp_char), 32'h20);
    disp_random(20);

    // Scroll caused by a printable in the last column, with display traffic
    n = COLS - m_col;
    for (int i = 0; i < n; i++) send_byte($urandom_range(33, 126), 0, 40);
    check("scroll2_top", 32'(top_row), 2);
    disp_random(20);

    // Reset in the middle of a clear
    model_byte(8'h0A);
    obs_a.delete();
    obs_d.delete();
    in_valid = 1'b1;
    in_char  = 8'h0A;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    repeat (3) begin
      #1;
      check("we_reset_mid", 32'(mem_we), 0);
      tick();
    end
    reset = 1'b0;
    check("mid_writes", obs_a.size(), 10);
    for (int i = 0; i < 10 && i < obs_a.size() && i < exp_a.size(); i++) begin
      check("mid_addr", obs_a[i], exp_a[i]);
      scr[exp_a[i]] = exp_d[i];
    end
    m_row = 0; m_col = 0; m_top = 0;
    tick();
    check("mid_cur_row", 32'(cur_row), 0);
    check("mid_cur_col", 32'(cur_col), 0);
    check("mid_top_row", 32'(top_row), 0);
    check("mid_in_ready", 32'(in_ready), 1);
    repeat (200) tick();
    check("mid_no_more", obs_a.size(), 10);
    $display("[TB] reset during clear: %0d writes before abort", obs_a.size());

    send_byte(8'h5A, 0, 0);
    check("post_rst_addr", (obs_a.size() > 0) ? obs_a[0] : -1, 0);
    disp_random(10);

    check("we_vs_disp_req", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
